// File: rtl/line_buffer_ctrl_pkg.sv
// Shared types and helpers for the line-buffer sequencer.
// STRIDE_EN (optional macro) enables strided window qualification.
package line_buffer_ctrl_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    RUN   = ST_RUN,
    DRAIN = ST_DRAIN
  } state_t;

  // Counter width for a bound, never narrower than one bit.
  function automatic int cnt_width(input int bound);
    return (bound < 2) ? 1 : $clog2(bound);
  endfunction

endpackage

// File: rtl/line_buffer_ctrl_pos_counter.sv
// Raster row/column position counter with accept enable and column-wrap flag.
// With STRIDE_EN defined it also tracks window phase modulo STRIDE.
module pos_counter
  import line_buffer_ctrl_pkg::*;
#(
  parameter int KERNEL_SIZE = 3,
  parameter int ROW_SIZE    = 5,
  parameter int COL_SIZE    = 5
`ifdef STRIDE_EN
  ,
  parameter int STRIDE      = 1
`endif
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          clear,
  input  logic                          accept,
  output logic [cnt_width(COL_SIZE)-1:0] row,
  output logic [cnt_width(ROW_SIZE)-1:0] col,
  output logic                          col_wrap
`ifdef STRIDE_EN
  ,
  output logic [cnt_width(STRIDE)-1:0]  row_phase,
  output logic [cnt_width(STRIDE)-1:0]  col_phase
`endif
);

  localparam int RW = cnt_width(COL_SIZE);
  localparam int CW = cnt_width(ROW_SIZE);
  localparam logic [RW-1:0] ROW_LAST = RW'(COL_SIZE - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(ROW_SIZE - 1);

  logic [RW-1:0] row_reg;
  logic [CW-1:0] col_reg;

  assign row      = row_reg;
  assign col      = col_reg;
  assign col_wrap = (col_reg == COL_LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      row_reg <= '0;
      col_reg <= '0;
    end else if (clear) begin
      row_reg <= '0;
      col_reg <= '0;
    end else if (accept) begin
      if (col_wrap) begin
        col_reg <= '0;
        row_reg <= (row_reg == ROW_LAST) ? '0 : row_reg + 1'b1;
      end else begin
        col_reg <= col_reg + 1'b1;
      end
    end
  end

`ifdef STRIDE_EN
  localparam int PW = cnt_width(STRIDE);
  localparam logic [PW-1:0] PH_LAST   = PW'(STRIDE - 1);
  localparam logic [RW-1:0] ROW_FIRST = RW'(KERNEL_SIZE - 1);
  localparam logic [CW-1:0] COL_FIRST = CW'(KERNEL_SIZE - 1);

  logic [PW-1:0] row_phase_reg;
  logic [PW-1:0] col_phase_reg;

  assign row_phase = row_phase_reg;
  assign col_phase = col_phase_reg;

  // Phases are anchored at K-1 so phase 0 means (pos-(K-1)) is a multiple of STRIDE.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      row_phase_reg <= '0;
      col_phase_reg <= '0;
    end else if (clear) begin
      row_phase_reg <= '0;
      col_phase_reg <= '0;
    end else if (accept) begin
      if (col_wrap) begin
        col_phase_reg <= '0;
        if (row_reg < ROW_FIRST) begin
          row_phase_reg <= '0;
        end else begin
          row_phase_reg <= (row_phase_reg == PH_LAST) ? '0 : row_phase_reg + 1'b1;
        end
      end else if (col_reg < COL_FIRST) begin
        col_phase_reg <= '0;
      end else begin
        col_phase_reg <= (col_phase_reg == PH_LAST) ? '0 : col_phase_reg + 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/line_buffer_ctrl.sv
// Line-buffer sequencer: frame FSM, pixel handshake and window-valid tracking.
// Optional macro STRIDE_EN restricts windows to multiples of STRIDE.
module line_buffer_ctrl
  import line_buffer_ctrl_pkg::*;
#(
  parameter int KERNEL_SIZE = 3,
  parameter int DATA_SIZE   = 8,
  parameter int ROW_SIZE    = 5,
  parameter int COL_SIZE    = 5,
  parameter int STRIDE      = 1
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           start,
  output logic                           busy,
  input  logic                           pixel_valid,
  output logic                           pixel_ready,
  input  logic [DATA_SIZE-1:0]           pixel_in,
  output logic                           lb_shift,
  output logic [DATA_SIZE-1:0]           lb_data,
  output logic                           window_valid,
  input  logic                           window_ready,
  output logic [cnt_width(COL_SIZE)-1:0] win_row,
  output logic [cnt_width(ROW_SIZE)-1:0] win_col,
  output logic                           frame_done
);

  localparam int RW = cnt_width(COL_SIZE);
  localparam int CW = cnt_width(ROW_SIZE);
  localparam logic [RW-1:0] ROW_FIRST = RW'(KERNEL_SIZE - 1);
  localparam logic [CW-1:0] COL_FIRST = CW'(KERNEL_SIZE - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(COL_SIZE - 1);

  if (KERNEL_SIZE < 2 || ROW_SIZE < KERNEL_SIZE || COL_SIZE < KERNEL_SIZE || STRIDE < 1)
  begin : g_param_check
    $error("line_buffer_ctrl: illegal parameter combination");
  end

  state_t        state_reg, state_next;
  logic          window_valid_reg;
  logic [RW-1:0] win_row_reg;
  logic [CW-1:0] win_col_reg;
  logic          frame_done_reg;

  logic [RW-1:0] row_cnt;
  logic [CW-1:0] col_cnt;
  logic          col_wrap;
  logic          accept;
  logic          clear;
  logic          last_pixel;
  logic          qualify;
  logic          phase_ok;

  assign clear       = (state_reg == IDLE) && start;
  assign pixel_ready = (state_reg == RUN) && (!window_valid_reg || window_ready);
  assign accept      = pixel_valid && pixel_ready;
  assign lb_shift    = accept;
  assign lb_data     = pixel_in;
  assign last_pixel  = col_wrap && (row_cnt == ROW_LAST);

  assign busy         = (state_reg != IDLE);
  assign window_valid = window_valid_reg;
  assign win_row      = win_row_reg;
  assign win_col      = win_col_reg;
  assign frame_done   = frame_done_reg;

`ifdef STRIDE_EN
  logic [cnt_width(STRIDE)-1:0] row_phase;
  logic [cnt_width(STRIDE)-1:0] col_phase;

  pos_counter #(
    .KERNEL_SIZE (KERNEL_SIZE),
    .ROW_SIZE    (ROW_SIZE),
    .COL_SIZE    (COL_SIZE),
    .STRIDE      (STRIDE)
  ) u_pos (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear     (clear),
    .accept    (accept),
    .row       (row_cnt),
    .col       (col_cnt),
    .col_wrap  (col_wrap),
    .row_phase (row_phase),
    .col_phase (col_phase)
  );

  assign phase_ok = (row_phase == '0) && (col_phase == '0);
`else
  pos_counter #(
    .KERNEL_SIZE (KERNEL_SIZE),
    .ROW_SIZE    (ROW_SIZE),
    .COL_SIZE    (COL_SIZE)
  ) u_pos (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear    (clear),
    .accept   (accept),
    .row      (row_cnt),
    .col      (col_cnt),
    .col_wrap (col_wrap)
  );

  assign phase_ok = 1'b1;
`endif

  // Columns below K-1 hold taps wrapped from the previous row, so they never qualify.
  assign qualify = accept && (row_cnt >= ROW_FIRST) && (col_cnt >= COL_FIRST) && phase_ok;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (accept && last_pixel) state_next = DRAIN;
      DRAIN:   if (!window_valid_reg || window_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg        <= IDLE;
      window_valid_reg <= 1'b0;
      win_row_reg      <= '0;
      win_col_reg      <= '0;
      frame_done_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      frame_done_reg <= (state_reg == DRAIN) && (state_next == IDLE);
      if (qualify) begin
        window_valid_reg <= 1'b1;
        win_row_reg      <= row_cnt - ROW_FIRST;
        win_col_reg      <= col_cnt - COL_FIRST;
      end else if (window_ready) begin
        window_valid_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Directed self-checking bench for line_buffer_ctrl (5x5 image, 3x3 kernel).
module tb_line_buffer_ctrl;

  localparam int K   = 3;
  localparam int DW  = 8;
  localparam int RS  = 5;
  localparam int CS  = 5;
  localparam int STR = 2;
`ifdef STRIDE_EN
  localparam int STEP = STR;
`else
  localparam int STEP = 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          pixel_valid = 1'b0;
  logic          window_ready = 1'b1;
  logic [DW-1:0] pixel_in = '0;
  logic          busy, pixel_ready, lb_shift, window_valid, frame_done;
  logic [DW-1:0] lb_data;
  logic [2:0]    win_row, win_col;

  always #5 clk = ~clk;

  line_buffer_ctrl #(
    .KERNEL_SIZE (K),
    .DATA_SIZE   (DW),
    .ROW_SIZE    (RS),
    .COL_SIZE    (CS),
    .STRIDE      (STR)
  ) dut (
    .clock        (clk),
    .reset_n      (rst_n),
    .start        (start),
    .busy         (busy),
    .pixel_valid  (pixel_valid),
    .pixel_ready  (pixel_ready),
    .pixel_in     (pixel_in),
    .lb_shift     (lb_shift),
    .lb_data      (lb_data),
    .window_valid (window_valid),
    .window_ready (window_ready),
    .win_row      (win_row),
    .win_col      (win_col),
    .frame_done   (frame_done)
  );

  int tests = 0;
  int fails = 0;

  // Observation log, sampled on the falling edge.
  int         cyc = 0;
  int         acc_cnt = 0;
  int         done_cnt = 0;
  int         data_err = 0;
  int         shift_err = 0;
  logic       wv_prev = 1'b0;
  int         acc_cyc_q[$];
  int         wv_rise_q[$];
  logic [5:0] win_q[$];
  logic [5:0] exp_q[$];

  always @(negedge clk) begin
    cyc++;
    if (lb_data !== pixel_in) data_err++;
    if (lb_shift !== (pixel_valid & pixel_ready)) shift_err++;
    if (rst_n) begin
      if (lb_shift) begin
        acc_cnt++;
        acc_cyc_q.push_back(cyc);
      end
      if (window_valid && window_ready) win_q.push_back({win_row, win_col});
      if (window_valid && !wv_prev) wv_rise_q.push_back(cyc);
      if (frame_done) done_cnt++;
    end
    wv_prev = window_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_frame(input bit gaps, input bit stall, input bit mid_start);
    int a0, w0, d0, n;
    bit stalled;
    a0 = acc_cnt;
    w0 = win_q.size();
    d0 = done_cnt;
    stalled = 1'b0;
    window_ready = 1'b1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("busy_after_start", busy, 1);
    n = 0;
    while (done_cnt == d0 && n < 400) begin
      pixel_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      pixel_in    = 8'($urandom_range(0, 255));
      start       = mid_start && (acc_cnt - a0 == 6);
      if (stall && !stalled && window_valid && win_row == 3'd1 && win_col == 3'd1) begin
        stalled      = 1'b1;
        window_ready = 1'b0;
        pixel_valid  = 1'b1;
        for (int s = 0; s < 4; s++) begin
          #1;
          check("stall_pixel_ready", pixel_ready, 0);
          check("stall_lb_shift", lb_shift, 0);
          check("stall_window_valid", window_valid, 1);
          check("stall_win_row", win_row, 1);
          check("stall_win_col", win_col, 1);
          @(posedge clk); #1;
        end
        window_ready = 1'b1;
      end
      @(posedge clk); #1;
      n++;
    end
    start       = 1'b0;
    pixel_valid = 1'b0;
    check("frame_in_time", (n < 400), 1);
    if (stall) check("stall_happened", stalled, 1);
    check("accept_count", acc_cnt - a0, RS * CS);
    check("window_count", win_q.size() - w0, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (w0 + i < win_q.size()) check("window_coord", win_q[w0 + i], exp_q[i]);
      else check("window_missing", 0, 1);
    end
    repeat (3) @(posedge clk);
    #1;
    check("frame_done_once", done_cnt - d0, 1);
    check("frame_done_low", frame_done, 0);
    check("idle_busy", busy, 0);
    check("idle_window_valid", window_valid, 0);
  endtask

  initial begin
    int a0, wr0, n;

    for (int r = 0; r <= CS - K; r += STEP)
      for (int c = 0; c <= RS - K; c += STEP)
        exp_q.push_back({3'(r), 3'(c)});

    // Reset values while reset_n is held low.
    pixel_in    = 8'hA5;
    pixel_valid = 1'b1;
    #12;
    check("rst_busy", busy, 0);
    check("rst_pixel_ready", pixel_ready, 0);
    check("rst_lb_shift", lb_shift, 0);
    check("rst_window_valid", window_valid, 0);
    check("rst_win_row", win_row, 0);
    check("rst_win_col", win_col, 0);
    check("rst_frame_done", frame_done, 0);
    check("lb_data_passthru", lb_data, 8'hA5);

    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_no_ready", pixel_ready, 0);
    pixel_valid = 1'b0;

    // Gap-free frame with latency and throughput checks.
    a0  = acc_cnt;
    wr0 = wv_rise_q.size();
    run_frame(1'b0, 1'b0, 1'b0);
    if (acc_cyc_q.size() >= a0 + RS * CS && wv_rise_q.size() > wr0) begin
      check("first_window_latency", wv_rise_q[wr0] - acc_cyc_q[a0 + K * RS - RS + K - 1], 1);
      check("throughput_25_in_25", acc_cyc_q[a0 + RS * CS - 1] - acc_cyc_q[a0], RS * CS - 1);
    end else begin
      check("latency_samples_present", 0, 1);
    end

    // Consumer stall at window (1,1).
    run_frame(1'b0, 1'b1, 1'b0);

    // Random input gaps.
    run_frame(1'b1, 1'b0, 1'b0);

    // start asserted mid-frame is ignored.
    run_frame(1'b0, 1'b0, 1'b1);

    // Reset mid-frame after 10 accepts.
    a0 = acc_cnt;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    pixel_valid = 1'b1;
    n = 0;
    while (acc_cnt - a0 < 10 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("reached_10_accepts", acc_cnt - a0, 10);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_pixel_ready", pixel_ready, 0);
    check("midrst_lb_shift", lb_shift, 0);
    check("midrst_window_valid", window_valid, 0);
    check("midrst_win_row", win_row, 0);
    check("midrst_win_col", win_col, 0);
    check("midrst_frame_done", frame_done, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    a0 = acc_cnt;
    repeat (3) @(posedge clk);
    #1;
    check("postrst_needs_start", pixel_ready, 0);
    check("postrst_no_accepts", acc_cnt - a0, 0);
    pixel_valid = 1'b0;
    run_frame(1'b0, 1'b0, 1'b0);

    check("lb_data_tracking_errors", data_err, 0);
    check("lb_shift_tracking_errors", shift_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/line_buffer_ctrl.md
# line_buffer_ctrl

Sequencer for the shift-register line buffer in the convolution datapath. It accepts a raster-scan pixel stream with a valid/ready handshake and drives the buffer's shift enable and input data. It tracks the row and column position and flags each cycle where the buffer taps hold a complete, non-wrapping K×K window. Downstream backpressure stalls the input stream, so no window is lost or overwritten.

## Interface
- KERNEL_SIZE, 3: window edge K; K ≥ 2.
- DATA_SIZE, 8: pixel width in bits.
- ROW_SIZE, 5: image width in pixels; ≥ K.
- COL_SIZE, 5: image height in rows; ≥ K.
- STRIDE, 1: window stride; used only when STRIDE_EN is defined; ≥ 1.
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  begins a frame; sampled only in IDLE.
- busy  out  1  high in RUN and DRAIN.
- pixel_valid  in  1  input pixel present.
- pixel_ready  out  1  controller accepts pixel this cycle.
- pixel_in  in  DATA_SIZE  input pixel.
- lb_shift  out  1  line-buffer data_valid; equals pixel_valid & pixel_ready.
- lb_data  out  DATA_SIZE  line-buffer data_in; combinational pass-through of pixel_in.
- window_valid  out  1  buffer taps hold a valid window.
- window_ready  in  1  consumer takes the window.
- win_row  out  $clog2(COL_SIZE)  top-left row of the current window.
- win_col  out  $clog2(ROW_SIZE)  top-left column of the current window.
- frame_done  out  1  one-cycle pulse at end of frame.

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE → RUN when start=1. Row and column counters clear to 0. start in RUN or DRAIN is ignored.
- RUN: pixel_ready = !window_valid | window_ready. An accept is pixel_valid & pixel_ready.
- On each accept:
  - col increments; it wraps to 0 at ROW_SIZE-1 and row increments.
  - The accepted pixel is tagged (r, c) with the pre-increment counters.
- Window qualifies when r ≥ K-1 and c ≥ K-1. Columns c < K-1 hold wrap-around taps and never qualify.
- When a qualifying accept occurs:
  - window_valid sets next cycle.
  - win_row = r-(K-1) and win_col = c-(K-1) register at the same edge.
- window_valid clears on window_valid & window_ready, unless a new qualifying accept happens in the same cycle. In that case it stays high with the new coordinates, giving back-to-back windows.
- Accepting pixel (COL_SIZE-1, ROW_SIZE-1) moves RUN → DRAIN. pixel_ready is 0 outside RUN.
- DRAIN → IDLE when window_valid=0 or a handshake completes. frame_done pulses for one cycle, registered, on that transition.
- Per frame, without STRIDE_EN: exactly (ROW_SIZE-K+1)·(COL_SIZE-K+1) windows.
- Arithmetic: counters are unsigned and sized $clog2 of their bound. Subtractions happen only when the qualify test holds, so there is no underflow.

## Timing
- Reset values: state IDLE; busy 0, pixel_ready 0, window_valid 0, win_row 0, win_col 0, frame_done 0. lb_shift is 0 because pixel_ready is 0.
- lb_shift and lb_data are combinational. The line buffer captures on the same edge as the accept.
- Latency: window_valid rises 1 cycle after the accept that completes the window.
- Throughput: 1 pixel/cycle while window_ready=1.
- Stall: while window_valid=1 and window_ready=0, pixel_ready=0 and lb_shift=0. Buffer contents, win_row and win_col hold.
- reset_n low at any point, including mid-frame or during DRAIN: immediate return to reset values. A new start is required afterwards. Buffer contents are not cleared, and the next frame's fill overwrites them.
- start and reset_n deassertion in the same cycle: start is ignored.

## Configuration
- STRIDE_EN defined:
  - Row-phase and column-phase counters run modulo STRIDE. No divider is used.
  - A window qualifies only when (r-(K-1)) and (c-(K-1)) are both multiples of STRIDE.
  - The column phase resets on every row wrap.
  - Non-qualifying accepts still shift the buffer.
- STRIDE_EN undefined: STRIDE is ignored, the phase logic is absent, and every position with r, c ≥ K-1 qualifies.

## Structure
- Shared package holds:
  - state enum {IDLE, RUN, DRAIN};
  - a count-width function wrapping $clog2 with a minimum of 1.
- One sub-module, pos_counter: row/column counter with accept enable, wrap flag and, under STRIDE_EN, phase outputs.
- Top level holds the FSM, handshake and window registers.

## Test plan
- Defaults, continuous valid, window_ready=1 → 25 accepts in 25 cycles; first window_valid 1 cycle after the 13th accept at (0,0); 9 windows in raster order; frame_done once.
- window_ready held 0 for 4 cycles at window (1,1) → pixel_ready=0, no lb_shift, coordinates stable; release → frame resumes, still 9 windows.
- Random pixel_valid gaps → window count and coordinates identical to the gap-free run.
- STRIDE_EN, STRIDE=2, 5×5 → exactly 4 windows: (0,0), (0,2), (2,0), (2,2).
- reset_n pulsed low mid-frame after 10 accepts → all outputs at reset values; new start gives a full 9-window frame.
- start asserted during RUN → ignored; counters unaffected.
